// File: rtl/fir_stream_sequencer.sv
// Sequences coefficient loads and sample push/read transactions onto a downstream
// SCIE FIR unit, and returns the filtered result on a valid/ready output stream.
module fir_stream_sequencer #(
    parameter int unsigned NTAPS     = 5,
    parameter logic [31:0] INSN_LOAD = 32'd11,
    parameter logic [31:0] INSN_PUSH = 32'd43,
    parameter logic [31:0] INSN_READ = 32'd91
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [2:0]         cfg_index,
    input  logic signed [15:0] cfg_real,
    input  logic signed [15:0] cfg_imag,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] in_real,
    input  logic signed [15:0] in_imag,

    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] out_real,
    output logic signed [15:0] out_imag,

    output logic               fir_valid,
    output logic [31:0]        fir_insn,
    output logic signed [15:0] fir_rs1_real,
    output logic signed [15:0] fir_rs1_imag,
    output logic [31:0]        fir_rs2,
    input  logic signed [15:0] fir_rd_real,
    input  logic signed [15:0] fir_rd_imag,

    output logic [15:0]        sample_count,
    output logic               cfg_err
);

    localparam int unsigned DW = 16;
    localparam int unsigned IW = 32;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_PUSH    = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_READ    = 3'd4;
    localparam logic [2:0] ST_CAPTURE = 3'd5;

    logic [2:0]          state_q, state_d;
    logic                fir_valid_q, fir_valid_d;
    logic [IW-1:0]       fir_insn_q, fir_insn_d;
    logic signed [DW-1:0] fir_rs1_real_q, fir_rs1_real_d;
    logic signed [DW-1:0] fir_rs1_imag_q, fir_rs1_imag_d;
    logic [IW-1:0]       fir_rs2_q, fir_rs2_d;
    logic                out_valid_q, out_valid_d;
    logic signed [DW-1:0] out_real_q, out_real_d;
    logic signed [DW-1:0] out_imag_q, out_imag_d;
    logic [DW-1:0]       sample_count_q, sample_count_d;
    logic                cfg_err_q, cfg_err_d;

    logic cfg_fire;
    logic in_fire;
    logic idx_ok;

    // Handshake readies: cfg wins over a simultaneous sample, and a sample is only
    // taken when the output slot is free or emptying this cycle.
    assign cfg_ready = reset && (state_q == ST_IDLE);
    assign in_ready  = reset && (state_q == ST_IDLE) && !cfg_valid
                       && (!out_valid_q || out_ready);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign in_fire   = in_valid && in_ready;
    assign idx_ok    = IW'(cfg_index) < NTAPS;

    // Next-state and registered-output logic; fir_* are loaded for the state being entered.
    always_comb begin
        state_d        = state_q;
        fir_valid_d    = 1'b0;
        fir_insn_d     = '0;
        fir_rs1_real_d = '0;
        fir_rs1_imag_d = '0;
        fir_rs2_d      = '0;
        out_valid_d    = out_valid_q && !out_ready;
        out_real_d     = out_real_q;
        out_imag_d     = out_imag_q;
        sample_count_d = sample_count_q;
        cfg_err_d      = cfg_err_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_fire) begin
                    if (idx_ok) begin
                        state_d        = ST_LOAD;
                        fir_valid_d    = 1'b1;
                        fir_insn_d     = INSN_LOAD;
                        fir_rs1_real_d = cfg_real;
                        fir_rs1_imag_d = cfg_imag;
                        fir_rs2_d      = IW'(cfg_index);
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end else if (in_fire) begin
                    state_d        = ST_PUSH;
                    fir_valid_d    = 1'b1;
                    fir_insn_d     = INSN_PUSH;
                    fir_rs1_real_d = in_real;
                    fir_rs1_imag_d = in_imag;
                    sample_count_d = sample_count_q + 16'd1;
                end
            end
            ST_LOAD: state_d = ST_IDLE;
            ST_PUSH: state_d = ST_WAIT;
            ST_WAIT: begin
                state_d     = ST_READ;
                fir_valid_d = 1'b1;
                fir_insn_d  = INSN_READ;
            end
            ST_READ: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                // FIR result is valid this cycle; a concurrent out transfer is overridden.
                state_d     = ST_IDLE;
                out_valid_d = 1'b1;
                out_real_d  = fir_rd_real;
                out_imag_d  = fir_rd_imag;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            fir_valid_q    <= 1'b0;
            fir_insn_q     <= '0;
            fir_rs1_real_q <= '0;
            fir_rs1_imag_q <= '0;
            fir_rs2_q      <= '0;
            out_valid_q    <= 1'b0;
            out_real_q     <= '0;
            out_imag_q     <= '0;
            sample_count_q <= '0;
            cfg_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            fir_valid_q    <= fir_valid_d;
            fir_insn_q     <= fir_insn_d;
            fir_rs1_real_q <= fir_rs1_real_d;
            fir_rs1_imag_q <= fir_rs1_imag_d;
            fir_rs2_q      <= fir_rs2_d;
            out_valid_q    <= out_valid_d;
            out_real_q     <= out_real_d;
            out_imag_q     <= out_imag_d;
            sample_count_q <= sample_count_d;
            cfg_err_q      <= cfg_err_d;
        end
    end

    assign fir_valid    = fir_valid_q;
    assign fir_insn     = fir_insn_q;
    assign fir_rs1_real = fir_rs1_real_q;
    assign fir_rs1_imag = fir_rs1_imag_q;
    assign fir_rs2      = fir_rs2_q;
    assign out_valid    = out_valid_q;
    assign out_real     = out_real_q;
    assign out_imag     = out_imag_q;
    assign sample_count = sample_count_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// Scoreboard bench for fir_stream_sequencer: behavioural FIR unit, convolution
// reference model, directed scenarios followed by randomized traffic.
module tb_fir_stream_sequencer;

    localparam int NTAPS = 5;
    localparam logic [31:0] I_LOAD = 32'd11;
    localparam logic [31:0] I_PUSH = 32'd43;
    localparam logic [31:0] I_READ = 32'd91;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic cfg_valid = 1'b0, cfg_ready;
    logic [2:0] cfg_index = '0;
    logic signed [15:0] cfg_real = '0, cfg_imag = '0;
    logic in_valid = 1'b0, in_ready;
    logic signed [15:0] in_real = '0, in_imag = '0;
    logic out_valid, out_ready = 1'b0;
    logic signed [15:0] out_real, out_imag;
    logic fir_valid;
    logic [31:0] fir_insn, fir_rs2;
    logic signed [15:0] fir_rs1_real, fir_rs1_imag;
    logic signed [15:0] fir_rd_real = '0, fir_rd_imag = '0;
    logic [15:0] sample_count;
    logic cfg_err;

    fir_stream_sequencer #(
        .NTAPS(NTAPS), .INSN_LOAD(I_LOAD), .INSN_PUSH(I_PUSH), .INSN_READ(I_READ)
    ) dut (
        .clock(clock), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_index(cfg_index),
        .cfg_real(cfg_real), .cfg_imag(cfg_imag),
        .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
        .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
        .fir_valid(fir_valid), .fir_insn(fir_insn), .fir_rs1_real(fir_rs1_real),
        .fir_rs1_imag(fir_rs1_imag), .fir_rs2(fir_rs2),
        .fir_rd_real(fir_rd_real), .fir_rd_imag(fir_rd_imag),
        .sample_count(sample_count), .cfg_err(cfg_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0]        insn;
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic [31:0]        rs2;
    } issue_t;

    typedef struct {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx_t;

    issue_t exp_iss[$];
    cplx_t  exp_out[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;
    bit rand_rdy = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Downstream FIR unit: never reset by the sequencer, garbage on rd except after a read.
    int fc_re[NTAPS], fc_im[NTAPS], fh_re[NTAPS], fh_im[NTAPS];
    always @(posedge clock) begin
        if (fir_valid && fir_insn == I_READ) begin
            int sr, si;
            sr = 0; si = 0;
            for (int k = 0; k < NTAPS; k++) begin
                sr += fc_re[k] * fh_re[k] - fc_im[k] * fh_im[k];
                si += fc_re[k] * fh_im[k] + fc_im[k] * fh_re[k];
            end
            fir_rd_real <= 16'(sr);
            fir_rd_imag <= 16'(si);
        end else begin
            fir_rd_real <= 16'($urandom);
            fir_rd_imag <= 16'($urandom);
        end
        if (fir_valid && fir_insn == I_LOAD && fir_rs2 < 32'(NTAPS)) begin
            fc_re[int'(fir_rs2)] = int'(fir_rs1_real);
            fc_im[int'(fir_rs2)] = int'(fir_rs1_imag);
        end
        if (fir_valid && fir_insn == I_PUSH) begin
            for (int k = NTAPS - 1; k > 0; k--) begin
                fh_re[k] = fh_re[k-1];
                fh_im[k] = fh_im[k-1];
            end
            fh_re[0] = int'(fir_rs1_real);
            fh_im[0] = int'(fir_rs1_imag);
        end
    end

    // Reference model: loaded taps, accepted-sample history, counters.
    int m_cre[NTAPS], m_cim[NTAPS], m_hre[NTAPS], m_him[NTAPS];
    int m_count = 0;
    bit m_err   = 1'b0;

    function automatic cplx_t conv();
        cplx_t r;
        int sr, si;
        sr = 0; si = 0;
        for (int k = 0; k < NTAPS; k++) begin
            sr += m_cre[k] * m_hre[k] - m_cim[k] * m_him[k];
            si += m_cre[k] * m_him[k] + m_cim[k] * m_hre[k];
        end
        r.re = 16'(sr);
        r.im = 16'(si);
        return r;
    endfunction

    logic prev_rst = 1'b0, prev_ov = 1'b0, prev_or = 1'b0;
    logic signed [15:0] prev_re = '0, prev_im = '0;

    // Monitor: checks at the falling edge, then records transfers due at the next rising edge.
    always @(negedge clock) begin
        if (mon_en) begin
            issue_t e;
            cplx_t  o;
            if (fir_valid) begin
                if (exp_iss.size() == 0) begin
                    chk("fir_unexpected_issue", longint'(fir_insn), 0);
                end else begin
                    e = exp_iss.pop_front();
                    chk("fir_insn", longint'(fir_insn), longint'(e.insn));
                    chk("fir_rs1_real", fir_rs1_real, e.re);
                    chk("fir_rs1_imag", fir_rs1_imag, e.im);
                    chk("fir_rs2", longint'(fir_rs2), longint'(e.rs2));
                end
            end else begin
                chk("fir_idle_zero",
                    longint'(fir_insn != 0 || fir_rs2 != 0 || fir_rs1_real != 0 || fir_rs1_imag != 0), 0);
            end

            if (!reset) begin
                chk("rst_cfg_ready", cfg_ready, 0);
                chk("rst_in_ready", in_ready, 0);
            end else begin
                chk("sample_count", sample_count, m_count);
                chk("cfg_err", cfg_err, m_err);
                if (in_ready) begin
                    chk("in_ready_cfg_prio", cfg_valid, 0);
                    chk("in_ready_out_free", out_valid && !out_ready, 0);
                    chk("in_ready_implies_cfg_ready", cfg_ready, 1);
                end
                if (prev_rst && prev_ov && !prev_or) begin
                    chk("out_hold_valid", out_valid, 1);
                    chk("out_hold_real", out_real, prev_re);
                    chk("out_hold_imag", out_imag, prev_im);
                end
                if (out_valid && out_ready) begin
                    if (exp_out.size() == 0) begin
                        chk("out_unexpected", out_real, 0);
                    end else begin
                        o = exp_out.pop_front();
                        chk("out_real", out_real, o.re);
                        chk("out_imag", out_imag, o.im);
                    end
                end
                if (cfg_valid && cfg_ready) begin
                    if (int'(cfg_index) < NTAPS) begin
                        m_cre[int'(cfg_index)] = int'(cfg_real);
                        m_cim[int'(cfg_index)] = int'(cfg_imag);
                        e.insn = I_LOAD; e.re = cfg_real; e.im = cfg_imag; e.rs2 = 32'(cfg_index);
                        exp_iss.push_back(e);
                    end else begin
                        m_err = 1'b1;
                    end
                end
                if (in_valid && in_ready) begin
                    for (int k = NTAPS - 1; k > 0; k--) begin
                        m_hre[k] = m_hre[k-1];
                        m_him[k] = m_him[k-1];
                    end
                    m_hre[0] = int'(in_real);
                    m_him[0] = int'(in_imag);
                    m_count  = (m_count + 1) % 65536;
                    e.insn = I_PUSH; e.re = in_real; e.im = in_imag; e.rs2 = '0;
                    exp_iss.push_back(e);
                    e.insn = I_READ; e.re = '0; e.im = '0; e.rs2 = '0;
                    exp_iss.push_back(e);
                    exp_out.push_back(conv());
                end
            end

            if (!reset) begin
                exp_iss.delete();
                exp_out.delete();
                m_count = 0;
                m_err   = 1'b0;
            end
        end
        prev_rst = reset;
        prev_ov  = out_valid;
        prev_or  = out_ready;
        prev_re  = out_real;
        prev_im  = out_imag;
    end

    always begin
        @(posedge clock);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic wait_hs(input bit is_in);
        int n;
        n = 0;
        forever begin
            @(negedge clock);
            if (is_in ? (in_valid && in_ready) : (cfg_valid && cfg_ready)) break;
            n++;
            if (n > 100) begin
                chk(is_in ? "in_handshake_timeout" : "cfg_handshake_timeout", 1, 0);
                break;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_cfg(input logic [2:0] idx, input int re, input int im);
        cfg_index = idx; cfg_real = 16'(re); cfg_imag = 16'(im); cfg_valid = 1'b1;
        wait_hs(1'b0);
        cfg_valid = 1'b0;
    endtask

    task automatic do_sample(input int re, input int im);
        in_real = 16'(re); in_imag = 16'(im); in_valid = 1'b1;
        wait_hs(1'b1);
        in_valid = 1'b0;
    endtask

    // Called just after the accept edge: sequencer must stay busy until out_valid 4 edges later.
    task automatic check_latency(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk({tag, "_in_ready_busy"}, in_ready, 0);
            @(posedge clock);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [15:0] hold_re, hold_im;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_real", out_real, 0);
        chk("rst_out_imag", out_imag, 0);
        chk("rst_fir_valid", fir_valid, 0);
        chk("rst_fir_data", longint'(fir_insn != 0 || fir_rs2 != 0 || fir_rs1_real != 0 || fir_rs1_imag != 0), 0);
        chk("rst_sample_count", sample_count, 0);
        chk("rst_cfg_err", cfg_err, 0);
        mon_en = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        out_ready = 1'b1;

        // Tap load and first sample
        do_cfg(3'd0, 19, 28);
        do_cfg(3'd1, 47, -28);
        do_cfg(3'd2, -34, 45);
        do_cfg(3'd3, 38, -13);
        do_cfg(3'd4, 10, 34);
        do_sample(-49, -33);
        check_latency("s1");
        chk("s1_out_real", out_real, -7);
        chk("s1_out_imag", out_imag, -1999);
        chk("s1_sample_count", sample_count, 1);

        do_sample(-5, -1);
        check_latency("s2");
        chk("s2_out_real", out_real, -3294);
        chk("s2_out_imag", out_imag, -338);

        // Output backpressure for 10 cycles with a sample waiting
        do_sample(100, -200);
        out_ready = 1'b0;
        check_latency("s3");
        hold_re = out_real;
        hold_im = out_imag;
        in_real = 16'(-300); in_imag = 16'(77); in_valid = 1'b1;
        repeat (10) begin
            @(negedge clock);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_fir_valid", fir_valid, 0);
            chk("bp_out_real", out_real, hold_re);
            chk("bp_out_imag", out_imag, hold_im);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(negedge clock);
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check_latency("s4");

        // Out-of-range index: consumed, no issue, sticky error
        do_cfg(3'd5, 1234, -1234);
        chk("bad_idx_err", cfg_err, 1);
        chk("bad_idx_cfg_ready", cfg_ready, 1);
        chk("bad_idx_no_issue", fir_valid, 0);
        do_cfg(3'd7, 5, 5);
        do_sample(31, -17);
        check_latency("s5");
        chk("bad_idx_err_sticky", cfg_err, 1);

        // Simultaneous cfg and sample: cfg first
        cfg_index = 3'd2; cfg_real = 16'(-20); cfg_imag = 16'(15); cfg_valid = 1'b1;
        in_real = 16'(12); in_imag = 16'(-9); in_valid = 1'b1;
        @(negedge clock);
        chk("prio_cfg_ready", cfg_ready, 1);
        chk("prio_in_ready", in_ready, 0);
        @(posedge clock);
        #1;
        cfg_valid = 1'b0;
        chk("prio_load_insn", longint'(fir_insn), longint'(I_LOAD));
        chk("prio_load_rs2", longint'(fir_rs2), 2);
        @(negedge clock);
        chk("prio_in_ready_load", in_ready, 0);
        @(negedge clock);
        chk("prio_in_ready_idle", in_ready, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        chk("prio_push_insn", longint'(fir_insn), longint'(I_PUSH));
        chk("prio_push_rs1", fir_rs1_real, 12);
        check_latency("s6");

        // Reset during WAIT abandons the sample
        do_sample(-7, 22);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_cfg_ready", cfg_ready, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        @(posedge clock);
        #1;
        chk("mid_rst_fir_valid", fir_valid, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_sample_count", sample_count, 0);
        chk("mid_rst_cfg_err", cfg_err, 0);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clock);
            chk("post_rst_no_read", fir_valid, 0);
        end
        @(posedge clock);
        #1;
        do_sample(15, -4);
        check_latency("s8");
        chk("s8_sample_count", sample_count, 1);

        // Randomized traffic with random output backpressure
        rand_rdy = 1'b1;
        repeat (150) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) do_cfg(3'($urandom_range(0, 7)), $urandom_range(0, 200) - 100,
                              $urandom_range(0, 200) - 100);
            else do_sample($urandom_range(0, 400) - 200, $urandom_range(0, 400) - 200);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && (exp_out.size() != 0 || exp_iss.size() != 0); i++) begin
            @(posedge clock);
            #1;
        end
        chk("drain_pending", exp_out.size() + exp_iss.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
